// File: rtl/pairing_host_if_if.sv
// Host-side bundle for pairing_host_if: command channel, operand input stream
// and result output stream. The host (or bench) uses the master modport and
// the loader uses the slave modport.
interface pairing_host_if_if #(
   parameter int unsigned DATA_W = 304,
   parameter int unsigned ADDR_W = 9
);
   logic              cmd_valid;
   logic              cmd_ready;
   logic [3:0]        cmd_func;
   logic [ADDR_W-1:0] cmd_ld_base;
   logic [ADDR_W:0]   cmd_ld_num;
   logic [ADDR_W-1:0] cmd_rd_base;
   logic [ADDR_W:0]   cmd_rd_num;
   logic              s_valid;
   logic              s_ready;
   logic [DATA_W-1:0] s_data;
   logic              m_valid;
   logic              m_ready;
   logic [DATA_W-1:0] m_data;

   modport master (
      output cmd_valid, cmd_func, cmd_ld_base, cmd_ld_num, cmd_rd_base, cmd_rd_num,
      output s_valid, s_data, m_ready,
      input  cmd_ready, s_ready, m_valid, m_data
   );

   modport slave (
      input  cmd_valid, cmd_func, cmd_ld_base, cmd_ld_num, cmd_rd_base, cmd_rd_num,
      input  s_valid, s_data, m_ready,
      output cmd_ready, s_ready, m_valid, m_data
   );
endinterface

// File: rtl/pairing_host_if.sv
// Loader/unloader for the BN254 pairing core: takes one command, writes the
// operand words into core RAM, pulses run, waits for endflag, then streams the
// result words out through a credit-controlled FIFO.
// Optional watchdog on the WAIT state: define PAIRING_HOSTIF_WDT_EN.
module pairing_host_if #(
   parameter int unsigned DATA_W      = 304,
   parameter int unsigned ADDR_W      = 9,
   parameter int unsigned RD_LAT      = 2,
   parameter int unsigned OFIFO_DEPTH = 4,
   parameter int unsigned WDT_W       = 24
) (
   input  logic               clk,
   input  logic               rstn,
   pairing_host_if_if.slave   host,
   output logic               core_run,
   output logic [3:0]         core_n_func,
   output logic               core_swrst,
   output logic               core_extin_en,
   output logic [ADDR_W-1:0]  core_extin_addr,
   output logic [DATA_W-1:0]  core_extin_data,
   output logic [ADDR_W-1:0]  core_extout_addr,
   input  logic [DATA_W-1:0]  core_extout_data,
   input  logic               core_busy,
   input  logic               core_endflag,
   output logic               done,
   output logic               err
);

   localparam int unsigned CntW = $clog2(OFIFO_DEPTH + 1);
   localparam int unsigned PtrW = (OFIFO_DEPTH > 1) ? $clog2(OFIFO_DEPTH) : 1;

   typedef enum logic [2:0] {StIdle, StLoad, StStart, StWait, StDrain, StDone} state_e;

   state_e              state_q, state_d;
   logic [3:0]          func_q;
   logic [ADDR_W-1:0]   ld_base_q, rd_base_q;
   logic [ADDR_W:0]     ld_num_q, rd_num_q, ld_cnt_q, rd_cnt_q;
   logic                extin_en_q;
   logic [ADDR_W-1:0]   extin_addr_q, addr_hold_q, rd_addr;
   logic [DATA_W-1:0]   extin_data_q;
   logic [RD_LAT-1:0]   vld_q;
   logic [DATA_W-1:0]   fifo_q [OFIFO_DEPTH];
   logic [PtrW-1:0]     wr_ptr_q, rd_ptr_q;
   logic [CntW-1:0]     fcnt_q, outst;
   logic                accept, load_hs, issue, push, pop, wdt_fire, busy_unused;

   assign accept  = (state_q == StIdle) && host.cmd_valid;
   assign load_hs = host.s_valid && host.s_ready;
   assign rd_addr = rd_base_q + rd_cnt_q[ADDR_W-1:0];
   assign push    = vld_q[RD_LAT-1];
   assign pop     = host.m_valid && host.m_ready;
   assign busy_unused = core_busy;

   assign host.cmd_ready = (state_q == StIdle);
   assign host.s_ready   = (state_q == StLoad) && (ld_cnt_q < ld_num_q);
   assign host.m_valid   = (fcnt_q != '0);
   assign host.m_data    = fifo_q[rd_ptr_q];
   assign core_run       = (state_q == StStart);
   assign done           = (state_q == StDone);
   assign core_n_func    = func_q;
   assign core_extin_en  = extin_en_q;
   assign core_extin_addr = extin_addr_q;
   assign core_extin_data = extin_data_q;
   // The address goes out in the issue cycle so the data returns RD_LAT cycles later.
   assign core_extout_addr = issue ? rd_addr : addr_hold_q;

   // Reads in flight: the popcount of the latency pipe.
   always_comb begin
      outst = '0;
      for (int i = 0; i < RD_LAT; i++) outst = outst + CntW'(vld_q[i]);
   end

   // Issue only while in-flight plus stored words leave room in the FIFO.
   always_comb begin
      issue = (state_q == StDrain) && (rd_cnt_q < rd_num_q) &&
              (({1'b0, outst} + {1'b0, fcnt_q}) < (CntW + 1)'(OFIFO_DEPTH));
   end

   // Next-state logic for the job sequencer.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (accept) state_d = StLoad;
         StLoad:  if (ld_cnt_q == ld_num_q) state_d = StStart;
         StStart: state_d = StWait;
         StWait: begin
            if (core_endflag) state_d = StDrain;
            else if (wdt_fire) state_d = StDone;
         end
         StDrain: if ((rd_cnt_q == rd_num_q) && (vld_q == '0) && (fcnt_q == '0))
            state_d = StDone;
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // State, command latches, load/read counters and the RAM write register.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q      <= StIdle;
         func_q       <= '0;
         ld_base_q    <= '0;
         rd_base_q    <= '0;
         ld_num_q     <= '0;
         rd_num_q     <= '0;
         ld_cnt_q     <= '0;
         rd_cnt_q     <= '0;
         extin_en_q   <= 1'b0;
         extin_addr_q <= '0;
         extin_data_q <= '0;
         addr_hold_q  <= '0;
      end else begin
         state_q    <= state_d;
         extin_en_q <= load_hs;
         if (accept) begin
            func_q    <= host.cmd_func;
            ld_base_q <= host.cmd_ld_base;
            rd_base_q <= host.cmd_rd_base;
            ld_num_q  <= host.cmd_ld_num;
            rd_num_q  <= host.cmd_rd_num;
            ld_cnt_q  <= '0;
            rd_cnt_q  <= '0;
         end
         if (load_hs) begin
            extin_addr_q <= ld_base_q + ld_cnt_q[ADDR_W-1:0];
            extin_data_q <= host.s_data;
            ld_cnt_q     <= ld_cnt_q + 1'b1;
         end
         if (issue) begin
            addr_hold_q <= rd_addr;
            rd_cnt_q    <= rd_cnt_q + 1'b1;
         end
      end
   end

   // Read-latency pipe and output FIFO pointers/occupancy.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         vld_q    <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         fcnt_q   <= '0;
      end else begin
         vld_q  <= RD_LAT'({vld_q, issue});
         fcnt_q <= fcnt_q + CntW'(push) - CntW'(pop);
         if (push) wr_ptr_q <= (wr_ptr_q == PtrW'(OFIFO_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= (rd_ptr_q == PtrW'(OFIFO_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
      end
   end

   // FIFO storage needs no reset; occupancy alone decides validity.
   always_ff @(posedge clk) begin
      if (push) fifo_q[wr_ptr_q] <= core_extout_data;
   end

`ifdef PAIRING_HOSTIF_WDT_EN
   logic [WDT_W-1:0] wdt_q;
   logic             err_q;

   assign wdt_fire   = (state_q == StWait) && !core_endflag && (&wdt_q);
   assign core_swrst = wdt_fire;
   assign err        = err_q;

   // Watchdog counts only in WAIT; it sits at zero elsewhere so entry restarts it.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wdt_q <= '0;
         err_q <= 1'b0;
      end else begin
         wdt_q <= (state_q == StWait) ? wdt_q + 1'b1 : '0;
         if (accept) err_q <= 1'b0;
         else if (wdt_fire) err_q <= 1'b1;
      end
   end
`else
   assign wdt_fire   = 1'b0;
   assign core_swrst = 1'b0;
   assign err        = 1'b0;
`endif

endmodule

// File: tb/tb_pairing_host_if.sv
// Bench for pairing_host_if: table of jobs plus hand-written reset and
// watchdog sequences, with a behavioural core (RAM read latency, endflag timer)
// and scoreboards for RAM writes and output words.
`timescale 1ns/1ps
module tb_pairing_host_if;
   localparam int unsigned DATA_W      = 304;
   localparam int unsigned ADDR_W      = 9;
   localparam int unsigned RD_LAT      = 2;
   localparam int unsigned OFIFO_DEPTH = 4;
`ifdef PAIRING_HOSTIF_WDT_EN
   localparam int unsigned WDT_W = 8;
`else
   localparam int unsigned WDT_W = 24;
`endif

   logic clk = 1'b0;
   logic rstn = 1'b1;
   always #5 clk = ~clk;

   logic              core_run, core_swrst, core_extin_en, core_busy, core_endflag, done, err;
   logic [3:0]        core_n_func;
   logic [ADDR_W-1:0] core_extin_addr, core_extout_addr;
   logic [DATA_W-1:0] core_extin_data, core_extout_data;

   pairing_host_if_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) hif ();

   pairing_host_if #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .RD_LAT(RD_LAT),
      .OFIFO_DEPTH(OFIFO_DEPTH), .WDT_W(WDT_W)
   ) dut (
      .clk(clk), .rstn(rstn), .host(hif.slave),
      .core_run(core_run), .core_n_func(core_n_func), .core_swrst(core_swrst),
      .core_extin_en(core_extin_en), .core_extin_addr(core_extin_addr),
      .core_extin_data(core_extin_data), .core_extout_addr(core_extout_addr),
      .core_extout_data(core_extout_data), .core_busy(core_busy),
      .core_endflag(core_endflag), .done(done), .err(err)
   );

   typedef struct {
      logic [8:0] ld_base;
      logic [9:0] ld_num;
      logic [8:0] rd_base;
      logic [9:0] rd_num;
      logic [3:0] func;
      logic [3:0] mpat;
      int         delay;
      logic [8:0] exp_wr_first;
      logic [8:0] exp_wr_last;
   } job_t;

   job_t jobs[5];

   int total = 0, bad = 0;
   int cyc = 0, done_cnt = 0, run_cnt = 0, wr_cnt = 0, pop_cnt = 0, swrst_cnt = 0;
   int swrst_cyc = 0, run_cyc = 0, ecnt = 0, endflag_delay = 0, mk = 0;
   logic [3:0]        exp_func = '0;
   logic [3:0]        mpat = 4'b1111;
   logic [ADDR_W-1:0] first_wa = '0, last_wa = '0;
   logic              first_seen = 1'b0;
   logic [ADDR_W-1:0] wa_q[$];
   logic [DATA_W-1:0] wd_q[$];
   logic [DATA_W-1:0] m_q[$];
   logic [ADDR_W-1:0] apipe[RD_LAT];

   function automatic logic [DATA_W-1:0] ld_word(int j, int i);
      return {19{16'(32'h5000 + j * 32 + i)}};
   endfunction

   function automatic logic [DATA_W-1:0] rd_word(logic [ADDR_W-1:0] a);
      return {19{16'hC000 | {7'b0, a}}};
   endfunction

   task automatic chk(string name, logic [DATA_W-1:0] act, logic [DATA_W-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic flag(string name);
      total++;
      bad++;
      $display("FAIL %s: got event want none", name);
   endtask

   // Monitor and behavioural core, evaluated mid-cycle.
   initial begin
      core_endflag = 1'b0;
      core_extout_data = '0;
      core_busy = 1'b0;
      for (int i = 0; i < RD_LAT; i++) apipe[i] = '0;
      forever begin
         @(negedge clk);
         cyc++;
         if (rstn) begin
            if (core_extin_en) begin
               if (wa_q.size() == 0) flag("extin_unexpected");
               else begin
                  chk("extin_addr", core_extin_addr, wa_q.pop_front());
                  chk("extin_data", core_extin_data, wd_q.pop_front());
               end
               if (!first_seen) first_wa = core_extin_addr;
               first_seen = 1'b1;
               last_wa = core_extin_addr;
               wr_cnt++;
            end
            if (hif.m_valid && m_q.size() == 0) flag("m_valid_spurious");
            else if (hif.m_valid && hif.m_ready) begin
               chk("m_data", hif.m_data, m_q.pop_front());
               pop_cnt++;
            end
            if (done) done_cnt++;
            if (core_swrst) begin
               swrst_cnt++;
               swrst_cyc = cyc;
            end
            if (core_run) begin
               run_cnt++;
               run_cyc = cyc;
               chk("n_func", core_n_func, exp_func);
            end
            core_endflag = 1'b0;
            if (ecnt > 0) begin
               ecnt--;
               if (ecnt == 0) core_endflag = 1'b1;
            end
            if (core_run && endflag_delay > 0) ecnt = endflag_delay;
            core_busy = (ecnt > 0);
            core_extout_data = rd_word(apipe[RD_LAT-1]);
            for (int i = RD_LAT - 1; i > 0; i--) apipe[i] = apipe[i-1];
            apipe[0] = core_extout_addr;
         end
      end
   end

   // Output backpressure follows the current 4-cycle pattern.
   initial begin
      hif.m_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         hif.m_ready = mpat[mk % 4];
         mk++;
      end
   end

   initial begin
      #500_000;
      $display("FAIL global_timeout: got running want finished");
      $fatal(1);
   end

   task automatic send_cmd(job_t t);
      int n = 0;
      @(posedge clk);
      #1;
      hif.cmd_valid = 1'b1;
      hif.cmd_func = t.func;
      hif.cmd_ld_base = t.ld_base;
      hif.cmd_ld_num = t.ld_num;
      hif.cmd_rd_base = t.rd_base;
      hif.cmd_rd_num = t.rd_num;
      @(negedge clk);
      while (!hif.cmd_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!hif.cmd_ready) flag("cmd_ready_timeout");
      @(posedge clk);
      #1;
      hif.cmd_valid = 1'b0;
   endtask

   task automatic send_words(int j, int num);
      for (int i = 0; i < num; i++) begin
         int n = 0;
         hif.s_valid = 1'b1;
         hif.s_data = ld_word(j, i);
         @(negedge clk);
         while (!hif.s_ready && n < 100) begin
            @(negedge clk);
            n++;
         end
         if (!hif.s_ready) flag("s_ready_timeout");
         @(posedge clk);
         #1;
         hif.s_valid = 1'b0;
         if (i % 3 == 1) begin
            @(posedge clk);
            #1;
         end
      end
   endtask

   task automatic wait_done(int limit);
      int start = done_cnt;
      int n = 0;
      while (done_cnt == start && n < limit) begin
         @(negedge clk);
         n++;
      end
      repeat (4) @(negedge clk);
   endtask

   task automatic prep_job(job_t t, int j, logic with_reads);
      exp_func = t.func;
      endflag_delay = t.delay;
      mpat = t.mpat;
      first_seen = 1'b0;
      for (int i = 0; i < int'(t.ld_num); i++) begin
         wa_q.push_back(ADDR_W'(t.ld_base + i));
         wd_q.push_back(ld_word(j, i));
      end
      if (with_reads)
         for (int i = 0; i < int'(t.rd_num); i++) m_q.push_back(rd_word(ADDR_W'(t.rd_base + i)));
   endtask

   task automatic run_job(int j);
      job_t t = jobs[j];
      int d0 = done_cnt, r0 = run_cnt, w0 = wr_cnt, p0 = pop_cnt;
      prep_job(t, j, 1'b1);
      send_cmd(t);
      send_words(j, int'(t.ld_num));
      wait_done(3000);
      chk("done_pulses", 32'(done_cnt - d0), 32'd1);
      chk("run_pulses", 32'(run_cnt - r0), 32'd1);
      chk("extin_writes", 32'(wr_cnt - w0), 32'(t.ld_num));
      chk("m_words", 32'(pop_cnt - p0), 32'(t.rd_num));
      chk("writes_left", 32'(wa_q.size()), 32'd0);
      chk("words_left", 32'(m_q.size()), 32'd0);
      chk("cmd_ready_after", hif.cmd_ready, 1'b1);
      chk("err_after", err, 1'b0);
      if (t.ld_num != 0) begin
         chk("first_wr_addr", first_wa, t.exp_wr_first);
         chk("last_wr_addr", last_wa, t.exp_wr_last);
      end
   endtask

   initial begin
      int p0, n, r0;
      jobs[0] = '{9'h010, 10'd3, 9'h020, 10'd2, 4'h3, 4'b1111, 100, 9'h010, 9'h012};
      jobs[1] = '{9'h040, 10'd2, 9'h030, 10'd8, 4'h5, 4'b1001, 20,  9'h040, 9'h041};
      jobs[2] = '{9'h1FE, 10'd4, 9'h1FE, 10'd4, 4'h7, 4'b1111, 20,  9'h1FE, 9'h001};
      jobs[3] = '{9'h000, 10'd0, 9'h000, 10'd0, 4'h1, 4'b1111, 5,   9'h000, 9'h000};
      jobs[4] = '{9'h100, 10'd6, 9'h1FC, 10'd6, 4'hA, 4'b0110, 30,  9'h100, 9'h105};
      hif.cmd_valid = 1'b0;
      hif.cmd_func = '0;
      hif.cmd_ld_base = '0;
      hif.cmd_ld_num = '0;
      hif.cmd_rd_base = '0;
      hif.cmd_rd_num = '0;
      hif.s_valid = 1'b0;
      hif.s_data = '0;

      // Reset values.
      #1 rstn = 1'b0;
      #1;
      chk("rst_cmd_ready", hif.cmd_ready, 1'b1);
      chk("rst_s_ready", hif.s_ready, 1'b0);
      chk("rst_m_valid", hif.m_valid, 1'b0);
      chk("rst_run", core_run, 1'b0);
      chk("rst_extin_en", core_extin_en, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_swrst", core_swrst, 1'b0);
      chk("rst_err", err, 1'b0);
      repeat (3) @(negedge clk);
      rstn = 1'b1;

      for (int j = 0; j < 5; j++) begin
         run_job(j);
         if (j == 0) chk("extout_addr_hold", core_extout_addr, 9'h021);
      end

      // Reset in the middle of DRAIN, then a normal job.
      begin
         job_t t = '{9'h050, 10'd1, 9'h080, 10'd5, 4'h2, 4'b1111, 10, 9'h050, 9'h050};
         p0 = pop_cnt;
         n = 0;
         prep_job(t, 7, 1'b1);
         send_cmd(t);
         send_words(7, 1);
         while (pop_cnt < p0 + 2 && n < 500) begin
            @(negedge clk);
            n++;
         end
         chk("pre_reset_pops", 32'(pop_cnt - p0), 32'd2);
         #1 rstn = 1'b0;
         #1;
         chk("midrst_cmd_ready", hif.cmd_ready, 1'b1);
         chk("midrst_m_valid", hif.m_valid, 1'b0);
         chk("midrst_extout_addr", core_extout_addr, 9'h000);
         chk("midrst_n_func", core_n_func, 4'h0);
         chk("midrst_done", done, 1'b0);
         m_q.delete();
         wa_q.delete();
         wd_q.delete();
         ecnt = 0;
         core_endflag = 1'b0;
         repeat (2) @(negedge clk);
         rstn = 1'b1;
         run_job(0);
      end

`ifdef PAIRING_HOSTIF_WDT_EN
      // Core never finishes: watchdog aborts the job without draining.
      begin
         job_t t = '{9'h060, 10'd1, 9'h070, 10'd2, 4'h9, 4'b1111, 0, 9'h060, 9'h060};
         int s0 = swrst_cnt;
         int d0 = done_cnt;
         p0 = pop_cnt;
         r0 = run_cnt;
         prep_job(t, 8, 1'b0);
         send_cmd(t);
         send_words(8, 1);
         wait_done(1000);
         chk("wdt_swrst_pulses", 32'(swrst_cnt - s0), 32'd1);
         chk("wdt_swrst_delay", 32'(swrst_cyc - run_cyc), 32'd256);
         chk("wdt_done", 32'(done_cnt - d0), 32'd1);
         chk("wdt_run", 32'(run_cnt - r0), 32'd1);
         chk("wdt_err", err, 1'b1);
         chk("wdt_no_drain", 32'(pop_cnt - p0), 32'd0);
         t = jobs[3];
         prep_job(t, 3, 1'b1);
         send_cmd(t);
         chk("wdt_err_cleared", err, 1'b0);
         wait_done(500);
      end
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
